sipo_rx: RTL
============

// Module: sipo_rx
// PURPOSE
//  Serial-in parallel-out receiver: the other end of the team's parallel shift-register path.
//  Collects a qualified serial bit stream into WIDTH-bit words, MSB-first or LSB-first.
//  Presents each completed word on a holding register with a valid/ack handshake to downstream logic.
//  Flags overrun when a word completes while the previous one is still unclaimed.
// PARAMETERS
//  WIDTH  16  word length in bits (>=2); bit counter is $clog2(WIDTH) bits wide
// PORTS
//  clk          in   1          rising-edge clock; single clock domain
//  reset        in   1          synchronous, active-high reset
//  serial_in    in   1          serial data bit; sampled only when bit_valid=1
//  bit_valid    in   1          qualifies serial_in for this cycle
//  msb_first    in   1          1=first received bit lands in data_out[WIDTH-1]; 0=in data_out[0]
//  resync       in   1          forces the bit counter back to 0 (frame realign)
//  data_out     out  WIDTH      last completed word (holding register)
//  data_valid   out  1          data_out holds an unclaimed word
//  data_ack     in   1          consumer takes data_out; effective only when data_valid=1
//  bit_count    out  clog2(W)   bits captured in the current partial word
//  overrun      out  1          sticky: a completed word was dropped
//  overrun_clr  in   1          clears overrun
// BEHAVIOUR
//  Reset (reset=1 at clk edge): shreg=0, bit_count=0, data_out=0, data_valid=0, overrun=0, mode latch=1.
//   Reset beats all other inputs; a partial word in flight is discarded.
//  Mode: msb_first is latched when a bit is accepted with bit_count==0 and held for the rest of the word;
//   changing msb_first mid-word has no effect until the next word.
//  Shift per accepted bit (bit_valid=1):
//   MSB-first: shreg <= {shreg[WIDTH-2:0], serial_in}
//   LSB-first: shreg <= {serial_in, shreg[WIDTH-1:1]}
//   bit_count increments; wraps WIDTH-1 -> 0 on the completing bit.
//  Completion: the accepted bit taken with bit_count==WIDTH-1 completes the word.
//   The full word (shreg incl. that bit) is written to data_out at the same edge.
//   data_valid=1 from the following cycle: latency = 1 clk after the last bit's edge.
//  Handshake: data_valid stays 1 and data_out stays stable until a cycle with data_ack=1.
//   data_valid drops at that edge. data_ack while data_valid=0 is ignored.
//  Overrun: the word completes with data_valid=1 and data_ack=0:
//   new word is dropped, data_out keeps the old word, overrun<=1.
//   overrun stays 1 until overrun_clr or reset.
//  Simultaneous cases:
//   completion + data_ack (data_valid=1): new word loaded, data_valid stays 1, no overrun.
//   resync + bit_valid: the counter restarts; the accepted bit is bit 0 of the new word.
//    msb_first is latched on it.
//   resync alone: bit_count<=0; partial shreg contents ignored; data_out/data_valid untouched.
//   overrun set + overrun_clr in the same cycle: set wins, overrun=1.
//  bit_valid=0: shreg, bit_count and the mode latch hold their values; handshake still operates.
//  Control FSM: EMPTY (data_valid=0) / FULL (data_valid=1).
//   EMPTY->FULL on completion.
//   FULL->EMPTY on ack without completion.
//   FULL->FULL on completion + ack (reload) or on completion without ack (overrun).
// TESTING
//  1 MSB-first: 16 bits of 16'hACF1, MSB first, one per clk
//    -> data_out=16'hACF1, data_valid=1 one clk after the 16th bit, bit_count=0.
//  2 LSB-first: same bit sequence with msb_first=0 -> data_out=16'h8F35 (bit-reversed).
//  3 Gapped bit_valid (random idle cycles between bits)
//    -> same words as 1/2; bit_count holds during gaps.
//  4 No ack: send 16'hACF1 then 16'h1234
//    -> data_out stays 16'hACF1, overrun=1; overrun_clr -> overrun=0.
//    Completion + ack in the same cycle -> 16'h1234 loaded, no overrun.
//  5 resync after 5 bits, then 16 bits of 16'h00FF
//    -> data_out=16'h00FF; msb_first toggled mid-word is ignored.
//  6 reset asserted mid-word (bit_count=7) and while data_valid=1
//    -> all outputs 0 next cycle; the next full word decodes correctly.

Source files
------------

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : Serial-in parallel-out receiver. Packs qualified serial bits
//               into WIDTH-bit words and hands them off with valid/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_in,
    input  logic                     bit_valid,
    input  logic                     msb_first,
    input  logic                     resync,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    input  logic                     data_ack,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_data;
    logic [c_cnt_w-1:0] r_bit_count;
    logic               r_mode;
    logic               r_overrun;

    logic [c_cnt_w-1:0] w_cnt;
    logic               w_mode;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic               w_complete;
    logic               w_load;
    logic               w_drop;

    // A resync folds into the same cycle's bit, so that bit starts a new word.
    always_comb begin
        w_cnt       = resync ? '0 : r_bit_count;
        w_mode      = (w_cnt == '0) ? msb_first : r_mode;
        w_shreg_nxt = w_mode ? {r_shreg[WIDTH-2:0], serial_in}
                             : {serial_in, r_shreg[WIDTH-1:1]};
        w_complete  = bit_valid && (w_cnt == c_last);
        w_load      = w_complete && ((r_state == c_st_empty) || data_ack);
        w_drop      = w_complete && (r_state == c_st_full) && !data_ack;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_complete) w_state_nxt = c_st_full;
            c_st_full:  if (!w_complete && data_ack) w_state_nxt = c_st_empty;
            default:    w_state_nxt = c_st_empty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg     <= '0;
            r_bit_count <= '0;
            r_mode      <= 1'b1;
            r_data      <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (bit_valid) begin
                r_shreg     <= w_shreg_nxt;
                r_mode      <= w_mode;
                r_bit_count <= w_complete ? '0 : w_cnt + 1'b1;
            end else if (resync) begin
                r_bit_count <= '0;
            end
            if (w_load) begin
                r_data <= w_shreg_nxt;
            end
            // Setting a fresh overrun outranks a same-cycle clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = (r_state == c_st_full);
    assign bit_count  = r_bit_count;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
